monte_carlo_multi_stat: RTL and testbench
=========================================

Name: monte_carlo_multi_stat

Overview:
Multi-lane successor to the single-engine Monte Carlo statistics collector. It drives NUM_LANES independent 2048 trial engines, typically one per candidate first move. Each lane repeatedly resets its engine, waits for stuck, and accumulates per-lane max, total and trial count until a programmable trial budget is reached. It then scans the lanes for the best total and reports through a start/busy/done handshake, with abort support.

Parameters:
NUM_LANES, 4, number of trial engines and statistic channels (1..16)
MOVE_W, 15, width of an engine's succ_count
ACC_W, 32, width of each per-lane total accumulator (saturating)
TRIAL_W, 16, width of trial budget and per-lane trial counters
LANE_IDX_W, 2, width of best_lane (>= clog2(NUM_LANES), minimum 1)

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
start  in  1  begin a run; sampled only in IDLE
abort  in  1  end the run early; sampled only in RUN
trial_budget  in  TRIAL_W  trials per lane; latched on start
lane_stuck  in  NUM_LANES  per-lane engine game-over flag
lane_succ_count  in  NUM_LANES*MOVE_W  per-lane move count; lane i at bits [i*MOVE_W +: MOVE_W]
lane_rst  out  NUM_LANES  one-cycle engine reset pulse per trial
busy  out  1  high from the cycle after start until the done cycle, inclusive
done  out  1  one-cycle pulse when results are valid
aborted  out  1  high with done if the run was aborted; held until next start
lane_max  out  NUM_LANES*MOVE_W  per-lane maximum succ_count
lane_total  out  NUM_LANES*ACC_W  per-lane summed succ_count
lane_trials  out  NUM_LANES*TRIAL_W  per-lane completed trials
best_lane  out  LANE_IDX_W  lane with the highest total; ties go to the lowest index
best_total  out  ACC_W  total of best_lane

Behaviour:
- Reset: all outputs, stats and counters are 0; FSM goes to IDLE. Reset mid-run discards the run, and no done is issued.
- Top FSM states: IDLE, RUN, SCAN, DONE.
- IDLE: on start, latch the budget, clear all stats, best_lane, best_total and aborted.
  - If budget == 0, go to SCAN.
  - Otherwise go to RUN with every lane in LAUNCH.
  - start is ignored in every state except IDLE.
- Per-lane FSM (RUN only): LAUNCH -> GUARD -> WAIT -> (LAUNCH | FIN).
  - LAUNCH: lane_rst[i] = 1 for exactly 1 cycle.
  - GUARD: lane_rst[i] = 0; lane_stuck is ignored, because the engine may still show the stale flag.
  - WAIT: when lane_stuck[i] = 1, capture the lane's succ_count.
    - total += succ, saturating at 2^ACC_W-1.
    - Update max if succ > max, strictly greater.
    - trials += 1.
    - Go to FIN if trials+1 == budget, otherwise go to LAUNCH.
  - Updates are visible the cycle after stuck is sampled. The minimum trial period is 3 cycles.
  - FIN: lane idle; lane_rst = 0.
- RUN -> SCAN: in the cycle after all lanes reach FIN, or in the cycle after abort is sampled.
  - On abort, lanes in WAIT do not accumulate in the abort cycle.
  - Set aborted = 1; partial stats are retained.
- SCAN: sequential argmax over exactly NUM_LANES cycles, lane 0 first.
  - Replace the running best only if the lane's total > best_total, strictly greater.
  - Then go to DONE.
- DONE: done = 1 for one cycle, then go to IDLE. busy drops in the following cycle.
- Hold: stats, best_lane and best_total hold after done until the next accepted start.
- lane_rst is never asserted outside RUN.
- Latency with NUM_LANES=4, budget=1, stuck constantly high, start in cycle 0:
  - lane_rst cycle 1, GUARD cycle 2, stuck sampled cycle 3.
  - SCAN cycles 4-7, done cycle 8.
- Budget 0, start in cycle 0: SCAN cycles 1-4, done cycle 5, all stats 0, best_lane 0.

Test Plan:
1. Defaults, budget=1, all lanes stuck held 1, succ={10,20,30,5}, start cycle 0 -> lane_rst=4'hF only in cycle 1; done cycle 8; totals {10,20,30,5}; trials all 1; best_lane=2; best_total=30.
2. Budget=3; lane 1 stuck pulses with succ 7, 12, 9 after random delays; other lanes succ 4 -> lane1 max=12, total=28, trials=3; lane_rst on lane 1 exactly 3 times; done only after the slowest lane finishes.
3. Tie: all lanes succ=8, budget=2 -> all totals 16; best_lane=0; best_total=16.
4. ACC_W=8 override, budget=3, succ=100 each trial -> total saturates at 255; max=100; trials=3.
5. Abort in cycle 10 of a budget=100 run -> no lane_rst after cycle 10; done at SCAN end; aborted=1; trials <100 and equal to the observed stuck samples.
6. Budget=0 -> done cycle 5, all stats 0. Start pulsed while busy -> ignored. rst asserted mid-run -> all outputs 0, no done, next start runs normally.

Source files
------------

// File: rtl/monte_carlo_multi_stat_if.sv
// Control, engine and result signals of the multi-lane Monte Carlo statistics collector.
// The master side drives start/abort/budget and the engine flags; the slave side is the collector.
interface monte_carlo_multi_stat_if #(
    parameter int unsigned NUM_LANES  = 4,
    parameter int unsigned MOVE_W     = 15,
    parameter int unsigned ACC_W      = 32,
    parameter int unsigned TRIAL_W    = 16,
    parameter int unsigned LANE_IDX_W = 2
);
    logic                           start;
    logic                           abort;
    logic [TRIAL_W-1:0]             trial_budget;
    logic [NUM_LANES-1:0]           lane_stuck;
    logic [NUM_LANES*MOVE_W-1:0]    lane_succ_count;
    logic [NUM_LANES-1:0]           lane_rst;
    logic                           busy;
    logic                           done;
    logic                           aborted;
    logic [NUM_LANES*MOVE_W-1:0]    lane_max;
    logic [NUM_LANES*ACC_W-1:0]     lane_total;
    logic [NUM_LANES*TRIAL_W-1:0]   lane_trials;
    logic [LANE_IDX_W-1:0]          best_lane;
    logic [ACC_W-1:0]               best_total;

    modport master (
        output start, abort, trial_budget, lane_stuck, lane_succ_count,
        input  lane_rst, busy, done, aborted, lane_max, lane_total, lane_trials,
               best_lane, best_total
    );

    modport slave (
        input  start, abort, trial_budget, lane_stuck, lane_succ_count,
        output lane_rst, busy, done, aborted, lane_max, lane_total, lane_trials,
               best_lane, best_total
    );
endinterface

// File: rtl/monte_carlo_multi_stat.sv
// Runs NUM_LANES trial engines in parallel, accumulating per-lane max/total/trial count until the
// budget is met or the run is aborted, then scans the lanes for the best total.
module monte_carlo_multi_stat #(
    parameter int unsigned NUM_LANES  = 4,
    parameter int unsigned MOVE_W     = 15,
    parameter int unsigned ACC_W      = 32,
    parameter int unsigned TRIAL_W    = 16,
    parameter int unsigned LANE_IDX_W = 2
) (
    input logic                     clk,
    input logic                     rst,
    monte_carlo_multi_stat_if.slave bus
);
    // One spare bit above the wider operand so the saturation check sees the carry.
    localparam int unsigned SUM_W = ((MOVE_W > ACC_W) ? MOVE_W : ACC_W) + 1;

    typedef enum logic [1:0] {StIdle, StRun, StScan, StDone} state_e;
    typedef enum logic [1:0] {LnLaunch, LnGuard, LnWait, LnFin} lane_e;

    state_e                state_q, state_d;
    lane_e                 lane_q      [NUM_LANES];
    lane_e                 lane_d      [NUM_LANES];
    logic [MOVE_W-1:0]     max_q       [NUM_LANES];
    logic [MOVE_W-1:0]     max_d       [NUM_LANES];
    logic [ACC_W-1:0]      total_q     [NUM_LANES];
    logic [ACC_W-1:0]      total_d     [NUM_LANES];
    logic [TRIAL_W-1:0]    trials_q    [NUM_LANES];
    logic [TRIAL_W-1:0]    trials_d    [NUM_LANES];
    logic [TRIAL_W-1:0]    budget_q, budget_d;
    logic [LANE_IDX_W-1:0] best_lane_q, best_lane_d;
    logic [LANE_IDX_W-1:0] scan_idx_q, scan_idx_d;
    logic [ACC_W-1:0]      best_total_q, best_total_d;
    logic                  aborted_q, aborted_d;
    logic                  all_fin;
    logic [MOVE_W-1:0]     succ;
    logic [SUM_W-1:0]      sum;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            budget_q     <= '0;
            best_lane_q  <= '0;
            scan_idx_q   <= '0;
            best_total_q <= '0;
            aborted_q    <= 1'b0;
            for (int i = 0; i < NUM_LANES; i++) begin
                lane_q[i]   <= LnFin;
                max_q[i]    <= '0;
                total_q[i]  <= '0;
                trials_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            budget_q     <= budget_d;
            best_lane_q  <= best_lane_d;
            scan_idx_q   <= scan_idx_d;
            best_total_q <= best_total_d;
            aborted_q    <= aborted_d;
            for (int i = 0; i < NUM_LANES; i++) begin
                lane_q[i]   <= lane_d[i];
                max_q[i]    <= max_d[i];
                total_q[i]  <= total_d[i];
                trials_q[i] <= trials_d[i];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        budget_d     = budget_q;
        best_lane_d  = best_lane_q;
        scan_idx_d   = scan_idx_q;
        best_total_d = best_total_q;
        aborted_d    = aborted_q;
        lane_d       = lane_q;
        max_d        = max_q;
        total_d      = total_q;
        trials_d     = trials_q;
        all_fin      = 1'b1;
        succ         = '0;
        sum          = '0;

        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    budget_d     = bus.trial_budget;
                    best_lane_d  = '0;
                    best_total_d = '0;
                    aborted_d    = 1'b0;
                    scan_idx_d   = '0;
                    for (int i = 0; i < NUM_LANES; i++) begin
                        lane_d[i]   = (bus.trial_budget == '0) ? LnFin : LnLaunch;
                        max_d[i]    = '0;
                        total_d[i]  = '0;
                        trials_d[i] = '0;
                    end
                    state_d = (bus.trial_budget == '0) ? StScan : StRun;
                end
            end
            StRun: begin
                if (bus.abort) begin
                    // Abort wins over any stuck sample in the same cycle.
                    aborted_d  = 1'b1;
                    scan_idx_d = '0;
                    state_d    = StScan;
                end else begin
                    for (int i = 0; i < NUM_LANES; i++) begin
                        case (lane_q[i])
                            LnLaunch: lane_d[i] = LnGuard;
                            LnGuard:  lane_d[i] = LnWait;
                            LnWait: begin
                                if (bus.lane_stuck[i]) begin
                                    succ = bus.lane_succ_count[i*MOVE_W +: MOVE_W];
                                    sum  = SUM_W'(total_q[i]) + SUM_W'(succ);
                                    total_d[i] = (sum[SUM_W-1:ACC_W] != '0) ? '1 : sum[ACC_W-1:0];
                                    if (succ > max_q[i]) begin
                                        max_d[i] = succ;
                                    end
                                    trials_d[i] = trials_q[i] + 1'b1;
                                    lane_d[i]   = (trials_d[i] == budget_q) ? LnFin : LnLaunch;
                                end
                            end
                            default: lane_d[i] = LnFin;
                        endcase
                        if (lane_d[i] != LnFin) begin
                            all_fin = 1'b0;
                        end
                    end
                    if (all_fin) begin
                        scan_idx_d = '0;
                        state_d    = StScan;
                    end
                end
            end
            StScan: begin
                if (total_q[scan_idx_q] > best_total_q) begin
                    best_total_d = total_q[scan_idx_q];
                    best_lane_d  = scan_idx_q;
                end
                if (scan_idx_q == LANE_IDX_W'(NUM_LANES - 1)) begin
                    state_d = StDone;
                end else begin
                    scan_idx_d = scan_idx_q + 1'b1;
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        bus.lane_rst    = '0;
        bus.lane_max    = '0;
        bus.lane_total  = '0;
        bus.lane_trials = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            bus.lane_rst[i]                       = (state_q == StRun) && (lane_q[i] == LnLaunch);
            bus.lane_max[i*MOVE_W +: MOVE_W]      = max_q[i];
            bus.lane_total[i*ACC_W +: ACC_W]      = total_q[i];
            bus.lane_trials[i*TRIAL_W +: TRIAL_W] = trials_q[i];
        end
        bus.busy       = (state_q != StIdle);
        bus.done       = (state_q == StDone);
        bus.aborted    = aborted_q;
        bus.best_lane  = best_lane_q;
        bus.best_total = best_total_q;
    end
endmodule

// File: tb/tb_monte_carlo_multi_stat.sv
// Scoreboard bench: the driver queues hand-computed results per run, a negedge monitor pops and
// compares them on every done pulse. DUT B overrides ACC_W=8 to exercise saturation.
module tb_monte_carlo_multi_stat;
    typedef struct {
        logic [3:0][14:0] mx;
        logic [3:0][31:0] tot;
        logic [3:0][15:0] tr;
        logic [1:0]       bl;
        logic [31:0]      bt;
        logic             ab;
        int               done_rel;
        int               rn;
        int               fr;
    } exp_t;

    logic clk;
    logic rst;
    int   cyc;
    int   n_checks;
    int   n_fail;
    exp_t qa[$];
    exp_t qb[$];
    int   rcnt[2][4];
    int   first_r[2];
    int   start_c[2];

    // Engine model configuration for DUT A
    logic [3:0] stuck_cfg;
    int         succ_cfg[4];
    int         pulse_lane;
    int         pdly[$];
    int         pval[$];

    monte_carlo_multi_stat_if ifa ();
    monte_carlo_multi_stat_if #(.ACC_W(8)) ifb ();

    monte_carlo_multi_stat dut_a (.clk(clk), .rst(rst), .bus(ifa));
    monte_carlo_multi_stat #(.ACC_W(8)) dut_b (.clk(clk), .rst(rst), .bus(ifb));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic exp_t mk_exp(int n, int bl, int bt, int ab, int rel, int rn, int fr);
        exp_t e;
        for (int i = 0; i < 4; i++) begin
            e.mx[i]  = (n > 0) ? 15'(succ_cfg[i]) : 15'd0;
            e.tot[i] = 32'(n * succ_cfg[i]);
            e.tr[i]  = 16'(n);
        end
        e.bl       = 2'(bl);
        e.bt       = 32'(bt);
        e.ab       = 1'(ab);
        e.done_rel = rel;
        e.rn       = rn;
        e.fr       = fr;
        return e;
    endfunction

    // Lane engines: held lanes follow the config; the pulsed lane keeps a stale stuck flag through
    // LAUNCH and GUARD, drops it in WAIT, and raises it again after its programmed delay.
    initial begin
        int cnt;
        int dcur;
        int nxt;
        cnt  = 0;
        dcur = 0;
        nxt  = 0;
        ifa.lane_stuck      = '0;
        ifa.lane_succ_count = '0;
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < 4; i++) begin
                if (i == pulse_lane) begin
                    if (ifa.lane_rst[i]) begin
                        dcur = (pdly.size() != 0) ? pdly.pop_front() : 1;
                        nxt  = (pval.size() != 0) ? pval.pop_front() : 0;
                        cnt  = dcur + 2;
                    end else if (cnt > 0) begin
                        cnt--;
                        if (cnt == dcur) ifa.lane_stuck[i] = 1'b0;
                        if (cnt == 0) begin
                            ifa.lane_stuck[i]             = 1'b1;
                            ifa.lane_succ_count[i*15 +: 15] = 15'(nxt);
                        end
                    end
                end else begin
                    ifa.lane_stuck[i]             = stuck_cfg[i];
                    ifa.lane_succ_count[i*15 +: 15] = 15'(succ_cfg[i]);
                end
            end
        end
    end

    task automatic mon_step(input int w, input logic st, input logic bz, input logic dn,
                            input logic [3:0] lr, input exp_t a);
        exp_t  e;
        string t;
        t = (w == 0) ? "A" : "B";
        if (rst) begin
            for (int i = 0; i < 4; i++) rcnt[w][i] = 0;
            first_r[w] = -1;
            return;
        end
        if (st && !bz) begin
            start_c[w] = cyc;
            for (int i = 0; i < 4; i++) rcnt[w][i] = 0;
            first_r[w] = -1;
        end
        if (!bz && lr != 4'd0) chk($sformatf("%s.lane_rst_idle", t), 64'(lr), 64'd0);
        for (int i = 0; i < 4; i++) begin
            if (lr[i]) begin
                rcnt[w][i]++;
                if (first_r[w] < 0) first_r[w] = cyc - start_c[w];
            end
        end
        if (dn) begin
            if ((w == 0 && qa.size() == 0) || (w == 1 && qb.size() == 0)) begin
                chk($sformatf("%s.unexpected_done", t), 64'(dn), 64'd0);
            end else begin
                if (w == 0) e = qa.pop_front();
                else        e = qb.pop_front();
                for (int i = 0; i < 4; i++) begin
                    chk($sformatf("%s.max%0d", t, i), 64'(a.mx[i]), 64'(e.mx[i]));
                    chk($sformatf("%s.total%0d", t, i), 64'(a.tot[i]), 64'(e.tot[i]));
                    chk($sformatf("%s.trials%0d", t, i), 64'(a.tr[i]), 64'(e.tr[i]));
                    chk($sformatf("%s.rst_count%0d", t, i), 64'(rcnt[w][i]), 64'(e.rn));
                end
                chk($sformatf("%s.best_lane", t), 64'(a.bl), 64'(e.bl));
                chk($sformatf("%s.best_total", t), 64'(a.bt), 64'(e.bt));
                chk($sformatf("%s.aborted", t), 64'(a.ab), 64'(e.ab));
                chk($sformatf("%s.busy_at_done", t), 64'(bz), 64'd1);
                if (e.done_rel >= 0)
                    chk($sformatf("%s.done_cycle", t), 64'(cyc - start_c[w]), 64'(e.done_rel));
                if (e.fr >= 0)
                    chk($sformatf("%s.first_rst_cycle", t), 64'(first_r[w]), 64'(e.fr));
            end
        end
    endtask

    initial begin
        exp_t act;
        for (int w = 0; w < 2; w++) begin
            first_r[w] = -1;
            start_c[w] = 0;
            for (int i = 0; i < 4; i++) rcnt[w][i] = 0;
        end
        forever begin
            @(negedge clk);
            act.mx  = ifa.lane_max;
            act.tot = ifa.lane_total;
            act.tr  = ifa.lane_trials;
            act.bl  = ifa.best_lane;
            act.bt  = ifa.best_total;
            act.ab  = ifa.aborted;
            mon_step(0, ifa.start, ifa.busy, ifa.done, ifa.lane_rst, act);
            act.mx = ifb.lane_max;
            act.tr = ifb.lane_trials;
            for (int i = 0; i < 4; i++) act.tot[i] = 32'(ifb.lane_total[i*8 +: 8]);
            act.bl = ifb.best_lane;
            act.bt = 32'(ifb.best_total);
            act.ab = ifb.aborted;
            mon_step(1, ifb.start, ifb.busy, ifb.done, ifb.lane_rst, act);
        end
    end

    task automatic wait_q(input int w);
        for (int n = 0; n < 3000; n++) begin
            if ((w == 0 && qa.size() == 0) || (w == 1 && qb.size() == 0)) break;
            @(posedge clk);
        end
        chk((w == 0) ? "A.done_timeout" : "B.done_timeout",
            64'((w == 0) ? qa.size() : qb.size()), 64'd0);
    endtask

    task automatic run_a(input int budget, input int abort_at, input int restart_at);
        repeat (2) @(posedge clk);
        #1;
        ifa.trial_budget = 16'(budget);
        ifa.start        = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk);
            #1;
            ifa.abort        = (k == abort_at);
            ifa.start        = (k == restart_at);
            ifa.trial_budget = (k == restart_at) ? 16'd1 : 16'(budget);
        end
        @(posedge clk);
        #1;
        ifa.abort = 1'b0;
        ifa.start = 1'b0;
        wait_q(0);
    endtask

    task automatic chk_zero_a(input string t);
        chk({t, ".busy"}, 64'(ifa.busy), 64'd0);
        chk({t, ".done"}, 64'(ifa.done), 64'd0);
        chk({t, ".aborted"}, 64'(ifa.aborted), 64'd0);
        chk({t, ".lane_rst"}, 64'(ifa.lane_rst), 64'd0);
        chk({t, ".lane_max"}, 64'(ifa.lane_max), 64'd0);
        chk({t, ".lane_total_lo"}, ifa.lane_total[63:0], 64'd0);
        chk({t, ".lane_total_hi"}, ifa.lane_total[127:64], 64'd0);
        chk({t, ".lane_trials"}, ifa.lane_trials, 64'd0);
        chk({t, ".best_lane"}, 64'(ifa.best_lane), 64'd0);
        chk({t, ".best_total"}, 64'(ifa.best_total), 64'd0);
    endtask

    initial begin
        exp_t e;
        n_checks         = 0;
        n_fail           = 0;
        rst              = 1'b1;
        ifa.start        = 1'b0;
        ifa.abort        = 1'b0;
        ifa.trial_budget = '0;
        ifb.start        = 1'b0;
        ifb.abort        = 1'b0;
        ifb.trial_budget = '0;
        ifb.lane_stuck   = '1;
        for (int i = 0; i < 4; i++) ifb.lane_succ_count[i*15 +: 15] = 15'd100;
        stuck_cfg  = '1;
        succ_cfg   = '{10, 20, 30, 5};
        pulse_lane = -1;
        repeat (3) @(posedge clk);
        #1;
        chk_zero_a("reset");
        chk("reset.b_busy", 64'(ifb.busy), 64'd0);
        rst = 1'b0;

        // Budget 1, distinct totals
        qa.push_back(mk_exp(1, 2, 30, 0, 8, 1, 1));
        run_a(1, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("hold.best_total", 64'(ifa.best_total), 64'd30);
        chk("hold.lane2_total", 64'(ifa.lane_total[95:64]), 64'd30);
        chk("hold.busy", 64'(ifa.busy), 64'd0);

        // Lane 1 slow with stale stuck flag; others held at 4
        succ_cfg   = '{4, 4, 4, 4};
        pdly       = {3, 5, 2};
        pval       = {7, 12, 9};
        pulse_lane = 1;
        e          = mk_exp(3, 1, 28, 0, 24, 3, 1);
        e.mx[1]    = 15'd12;
        e.tot[1]   = 32'd28;
        qa.push_back(e);
        run_a(3, 0, 0);
        pulse_lane = -1;

        // Tie across all lanes
        succ_cfg = '{8, 8, 8, 8};
        qa.push_back(mk_exp(2, 0, 16, 0, 11, 2, 1));
        run_a(2, 0, 0);

        // 8-bit accumulator saturation
        e = mk_exp(3, 0, 255, 0, 14, 3, 1);
        for (int i = 0; i < 4; i++) begin
            e.mx[i]  = 15'd100;
            e.tot[i] = 32'd255;
        end
        qb.push_back(e);
        repeat (2) @(posedge clk);
        #1;
        ifb.trial_budget = 16'd3;
        ifb.start        = 1'b1;
        @(posedge clk);
        #1;
        ifb.start = 1'b0;
        wait_q(1);

        // Abort during LAUNCH (cycle 10) and during WAIT (cycle 9)
        succ_cfg = '{6, 2, 9, 4};
        qa.push_back(mk_exp(3, 2, 27, 1, 15, 4, 1));
        run_a(100, 10, 0);
        qa.push_back(mk_exp(2, 2, 18, 1, 14, 3, 1));
        run_a(100, 9, 0);

        // Zero budget
        qa.push_back(mk_exp(0, 0, 0, 0, 5, 0, -1));
        run_a(0, 0, 0);

        // Start pulsed while busy is ignored; tie between lanes 1 and 2
        succ_cfg = '{3, 7, 7, 1};
        qa.push_back(mk_exp(2, 1, 14, 0, 11, 2, 1));
        run_a(2, 0, 3);

        // Reset mid-run
        repeat (2) @(posedge clk);
        #1;
        ifa.trial_budget = 16'd100;
        ifa.start        = 1'b1;
        @(posedge clk);
        #1;
        ifa.start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("midrst.trials_before", 64'(ifa.lane_trials[15:0]), 64'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk_zero_a("midrst");
        repeat (20) @(posedge clk);

        // Normal run after reset
        succ_cfg = '{10, 20, 30, 5};
        qa.push_back(mk_exp(1, 2, 30, 0, 8, 1, 1));
        run_a(1, 0, 0);
        repeat (5) @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
